cdb_arbiter: RTL and testbench
==============================

// Module: cdb_arbiter
// PURPOSE
//  Common-data-bus arbiter: sits directly downstream of every reservation-station unit (ALU, mult, Mem_st).
//  Collects per-unit broadcast requests (label+data) and grants one per cycle.
//  Drives the single registered broadcast (BCEN/BClabel/BCdata) back to all stations and the register file.
//  Returns a one-cycle ack to the winner so it can free its station.
// PARAMETERS
//  N_REQ    4   number of requesting units (index 0..N_REQ-1)
//  LABEL_W  5   station label width; label 0 = "no producer / value ready"
//  DATA_W   32  broadcast data width
// PORTS
//  clk        in   1              clock, all state on posedge
//  nRST       in   1              reset, asynchronous, active-low
//  req        in   N_REQ          per-unit broadcast request, held until ack seen
//  label_in   in   N_REQ*LABEL_W  packed labels, unit i at [i*LABEL_W +: LABEL_W]
//  data_in    in   N_REQ*DATA_W   packed results, unit i at [i*DATA_W +: DATA_W]
//  ack        out  N_REQ          one-hot grant, high exactly one cycle (unit's BreqAC)
//  BCEN       out  1              broadcast valid
//  BClabel    out  LABEL_W        broadcast producer label
//  BCdata     out  DATA_W         broadcast value
//  err_label0 out  1              sticky: a request carried label 0
// BEHAVIOUR
//  - Reset (async): ack=0, BCEN=0, BClabel=0, BCdata=0, err_label0=0, rr pointer=0. Reset mid-broadcast drops it.
//  - Eligible(i) = req[i] & (label_i != 0) & ~ack[i] (current-cycle ack masks stale req of last winner).
//  - Posedge t: if any eligible, pick winner w. Cycle t+1: ack[w]=1, BCEN=1, BClabel=label_w, BCdata=data_w.
//    Latency req->broadcast = 1 cycle; ack and BCEN coincide.
//  - No eligible: ack=0, BCEN=0, BClabel/BCdata forced 0 (stations compare labels only when BCEN=1).
//  - Requester drops req on the posedge ending its ack cycle. The same unit cannot win two consecutive cycles.
//    Different units can win back-to-back: 1 broadcast/cycle sustained.
//  - Round-robin: search starts at ptr; after a grant ptr <= (w+1) mod N_REQ; ptr holds when idle.
//  - Label-0 request: never granted, err_label0 set (cleared only by reset).
//  - Two eligible units with equal label: both granted in turn, no merge (CU guarantees unique labels).
//  - req dropped before ack (illegal): simply not granted; no error.
// CONFIGURATION
//  CDB_FIXED_PRIO_EN defined:   lowest eligible index always wins.
//    ptr unused, tied 0; Mem unit wired at index 0.
//  CDB_FIXED_PRIO_EN undefined: round-robin as above (default).
//  All other behaviour, including ack masking and latency, is identical.
// STRUCTURE
//  - head.v (shared defines): station labels (`Mem0, `Mem1, ALU/mult labels), `LABEL_NONE=0, widths.
//  - Sub-module rr_pick: combinational one-hot pick from eligible vector + ptr.
//    Mask-and-fallback double search; fixed-priority path selected by macro.
//  - Top: eligibility, packed-bus mux by one-hot winner, output/ack/ptr registers, err flag.
// TESTING
//  1 Single: req[2]=1, label=`Mem0, data=32'hDEADBEEF at t0 -> t1 ack=4'b0100, BCEN=1, BClabel=`Mem0,
//    BCdata=DEADBEEF; req dropped -> t2 BCEN=0, bus 0.
//  2 RR fairness: req=4'b1111 held (each drops after own ack, re-raises next cycle).
//    Grants cycle 0,1,2,3,0,...; no unit waits >3 cycles.
//  3 Back-to-back masking: only req[1] held 3 cycles -> acks at t1, t3 only (t2 BCEN=0); ptr=2 after.
//  4 Label 0: req[3]=1, label=0 -> never acked, err_label0=1 from t1.
//    Simultaneous req[0] valid -> unit 0 granted normally.
//  5 Reset mid-op: nRST low during BCEN=1 -> all outputs 0 immediately (async).
//    After release, first grant searches from index 0.
//  6 CDB_FIXED_PRIO_EN build: req=4'b1010 repeatedly -> unit 1 wins whenever eligible.
//    Unit 3 wins only in unit 1's masked cycle.

Source files
------------

// File: rtl/cdb_arbiter_pkg.sv
// Shared definitions for the common-data-bus arbiter: default widths,
// station labels and small helpers.
package cdb_arbiter_pkg;

    localparam int N_REQ_DEF   = 4;
    localparam int LABEL_W_DEF = 5;
    localparam int DATA_W_DEF  = 32;

    // Label 0 means "no producer / value ready" and is never broadcast.
    localparam logic [4:0] LABEL_NONE  = 5'd0;
    localparam logic [4:0] LABEL_MEM0  = 5'd1;
    localparam logic [4:0] LABEL_MEM1  = 5'd2;
    localparam logic [4:0] LABEL_ALU0  = 5'd3;
    localparam logic [4:0] LABEL_ALU1  = 5'd4;
    localparam logic [4:0] LABEL_MULT0 = 5'd5;
    localparam logic [4:0] LABEL_MULT1 = 5'd6;

    // Requester slot assignment; the memory unit sits at index 0 so that it
    // has top priority in the fixed-priority build.
    typedef enum logic [1:0] {
        UNIT_MEM   = 2'd0,
        UNIT_ALU   = 2'd1,
        UNIT_MULT  = 2'd2,
        UNIT_SPARE = 2'd3
    } unit_idx_e;

    // Width of an index into N requesters (at least 1 bit).
    function automatic int ptr_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/cdb_arbiter_rr_pick.sv
// One-hot winner pick from an eligible vector.
// Default: round-robin, searching upward from ptr and wrapping to the lowest
// eligible index when nothing at or above ptr is eligible.
// CDB_FIXED_PRIO_EN: lowest eligible index always wins, ptr ignored.
module cdb_arbiter_rr_pick
    import cdb_arbiter_pkg::*;
#(
    parameter int N_REQ = N_REQ_DEF,
    parameter int PTR_W = ptr_w(N_REQ_DEF)
) (
    input  logic [N_REQ-1:0] elig,
    input  logic [PTR_W-1:0] ptr,
    output logic [N_REQ-1:0] gnt
);

    logic hit_hi;
    logic hit_lo;

`ifdef CDB_FIXED_PRIO_EN
    logic unused_ptr;
    assign unused_ptr = ^ptr;

    // Fixed priority: first eligible from index 0.
    always_comb begin
        gnt    = '0;
        hit_hi = 1'b0;
        hit_lo = 1'b0;
        for (int i = 0; i < N_REQ; i++) begin
            if (elig[i] && !hit_lo) begin
                gnt[i] = 1'b1;
                hit_lo = 1'b1;
            end
        end
    end
`else
    // Masked search (indices >= ptr) first, plain lowest-index search as fallback.
    always_comb begin
        gnt    = '0;
        hit_hi = 1'b0;
        hit_lo = 1'b0;
        for (int i = 0; i < N_REQ; i++) begin
            if (elig[i] && (PTR_W'(i) >= ptr) && !hit_hi) begin
                gnt[i] = 1'b1;
                hit_hi = 1'b1;
            end
        end
        if (!hit_hi) begin
            for (int i = 0; i < N_REQ; i++) begin
                if (elig[i] && !hit_lo) begin
                    gnt[i] = 1'b1;
                    hit_lo = 1'b1;
                end
            end
        end
    end
`endif

endmodule

// File: rtl/cdb_arbiter.sv
// Common-data-bus arbiter. Grants one requesting unit per cycle and drives
// the registered broadcast (BCEN/BClabel/BCdata) plus a one-cycle ack to the
// winner. The registered ack masks the winner's still-high request for one
// cycle so a unit never wins twice in a row.
// Build option: CDB_FIXED_PRIO_EN selects fixed priority (lowest index wins)
// instead of the default round-robin.
module cdb_arbiter
    import cdb_arbiter_pkg::*;
#(
    parameter int N_REQ   = N_REQ_DEF,
    parameter int LABEL_W = LABEL_W_DEF,
    parameter int DATA_W  = DATA_W_DEF
) (
    input  logic                       clk,
    input  logic                       nRST,
    input  logic [N_REQ-1:0]           req,
    input  logic [N_REQ*LABEL_W-1:0]   label_in,
    input  logic [N_REQ*DATA_W-1:0]    data_in,
    output logic [N_REQ-1:0]           ack,
    output logic                       BCEN,
    output logic [LABEL_W-1:0]         BClabel,
    output logic [DATA_W-1:0]          BCdata,
    output logic                       err_label0
);

    localparam int PTR_W = ptr_w(N_REQ);

    logic [N_REQ-1:0]   ack_q, ack_d;
    logic               bcen_q, bcen_d;
    logic [LABEL_W-1:0] label_q, label_d;
    logic [DATA_W-1:0]  data_q, data_d;
    logic               err_q, err_d;
    logic [PTR_W-1:0]   ptr_q, ptr_d;

    logic [N_REQ-1:0]   elig;
    logic [N_REQ-1:0]   lbl0;
    logic [N_REQ-1:0]   gnt;
    logic [PTR_W-1:0]   w_idx;

    for (genvar g = 0; g < N_REQ; g++) begin : g_elig
        logic [LABEL_W-1:0] lab;
        assign lab     = label_in[g*LABEL_W +: LABEL_W];
        assign lbl0[g] = req[g] & (lab == LABEL_W'(LABEL_NONE));
        assign elig[g] = req[g] & (lab != LABEL_W'(LABEL_NONE)) & ~ack_q[g];
    end

    cdb_arbiter_rr_pick #(
        .N_REQ (N_REQ),
        .PTR_W (PTR_W)
    ) u_pick (
        .elig (elig),
        .ptr  (ptr_q),
        .gnt  (gnt)
    );

    // Mux the winner's label/data onto the bus; idle cycles drive zeros.
    always_comb begin
        ack_d   = gnt;
        bcen_d  = |gnt;
        label_d = '0;
        data_d  = '0;
        w_idx   = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (gnt[i]) begin
                label_d = label_d | label_in[i*LABEL_W +: LABEL_W];
                data_d  = data_d  | data_in[i*DATA_W +: DATA_W];
                w_idx   = w_idx   | PTR_W'(i);
            end
        end
        err_d = err_q | (|lbl0);
`ifdef CDB_FIXED_PRIO_EN
        ptr_d = '0;
`else
        ptr_d = ptr_q;
        if (bcen_d) begin
            ptr_d = (w_idx == PTR_W'(N_REQ - 1)) ? '0 : w_idx + PTR_W'(1);
        end
`endif
    end

`ifdef CDB_FIXED_PRIO_EN
    logic unused_w;
    assign unused_w = ^w_idx;
`endif

    // Broadcast, ack, pointer and error registers; async reset drops any
    // in-flight broadcast.
    always_ff @(posedge clk or negedge nRST) begin
        if (!nRST) begin
            ack_q   <= '0;
            bcen_q  <= 1'b0;
            label_q <= '0;
            data_q  <= '0;
            err_q   <= 1'b0;
            ptr_q   <= '0;
        end else begin
            ack_q   <= ack_d;
            bcen_q  <= bcen_d;
            label_q <= label_d;
            data_q  <= data_d;
            err_q   <= err_d;
            ptr_q   <= ptr_d;
        end
    end

    assign ack        = ack_q;
    assign BCEN       = bcen_q;
    assign BClabel    = label_q;
    assign BCdata     = data_q;
    assign err_label0 = err_q;

endmodule

// File: tb/tb_cdb_arbiter.sv
// Self-checking bench for cdb_arbiter: a reference model predicts each
// cycle's bus, pushes it to a scoreboard queue, and the value is popped and
// compared once the DUT has clocked. Scenario tasks add targeted checks.
module tb_cdb_arbiter;
    import cdb_arbiter_pkg::*;

    localparam int N  = 4;
    localparam int LW = 5;
    localparam int DW = 32;

    logic              clk = 1'b0;
    logic              nRST;
    logic [N-1:0]      req;
    logic [N*LW-1:0]   label_in;
    logic [N*DW-1:0]   data_in;
    logic [N-1:0]      ack;
    logic              BCEN;
    logic [LW-1:0]     BClabel;
    logic [DW-1:0]     BCdata;
    logic              err_label0;

    always #5 clk = ~clk;

    cdb_arbiter #(.N_REQ(N), .LABEL_W(LW), .DATA_W(DW)) dut (
        .clk        (clk),
        .nRST       (nRST),
        .req        (req),
        .label_in   (label_in),
        .data_in    (data_in),
        .ack        (ack),
        .BCEN       (BCEN),
        .BClabel    (BClabel),
        .BCdata     (BCdata),
        .err_label0 (err_label0)
    );

    typedef struct packed {
        logic [N-1:0]  ack;
        logic          bcen;
        logic [LW-1:0] label;
        logic [DW-1:0] data;
        logic          err;
    } exp_t;

    exp_t sb[$];
    int total = 0;
    int bad   = 0;

    // reference model state
    logic [N-1:0] m_ack;
    int           m_ptr;
    logic         m_err;

    task automatic m_reset();
        m_ack = '0;
        m_ptr = 0;
        m_err = 1'b0;
    endtask

    task automatic set_unit(input int i, input logic [LW-1:0] l, input logic [DW-1:0] d);
        label_in[i*LW +: LW] = l;
        data_in[i*DW +: DW]  = d;
    endtask

    // Predict the bus for the cycle after the current inputs are clocked.
    task automatic model_step(output exp_t e);
        logic [N-1:0]  el;
        logic [LW-1:0] l;
        int            w;
        el = '0;
        w  = -1;
        for (int i = 0; i < N; i++) begin
            l = label_in[i*LW +: LW];
            if (req[i] && l == 0) m_err = 1'b1;
            el[i] = req[i] && (l != 0) && !m_ack[i];
        end
`ifdef CDB_FIXED_PRIO_EN
        for (int k = 0; k < N; k++) if (w < 0 && el[k]) w = k;
`else
        for (int k = 0; k < N; k++) if (w < 0 && el[(m_ptr + k) % N]) w = (m_ptr + k) % N;
`endif
        e.ack   = '0;
        e.bcen  = 1'b0;
        e.label = '0;
        e.data  = '0;
        if (w >= 0) begin
            e.ack[w] = 1'b1;
            e.bcen   = 1'b1;
            e.label  = label_in[w*LW +: LW];
            e.data   = data_in[w*DW +: DW];
            m_ptr    = (w + 1) % N;
        end
        e.err = m_err;
        m_ack = e.ack;
    endtask

    // Called at a negedge with inputs set; returns at the next negedge.
    task automatic step(input string tag);
        exp_t e;
        exp_t got;
        model_step(e);
        sb.push_back(e);
        @(posedge clk);
        #1;
        e   = sb.pop_front();
        got = {ack, BCEN, BClabel, BCdata, err_label0};
        total++;
        if (got !== e) begin
            bad++;
            $display("FAIL %s: got ack=%b bcen=%b label=%0d data=%h err=%b, want ack=%b bcen=%b label=%0d data=%h err=%b",
                     tag, got.ack, got.bcen, got.label, got.data, got.err,
                     e.ack, e.bcen, e.label, e.data, e.err);
        end
        @(negedge clk);
    endtask

    function automatic int onehot_idx(input logic [N-1:0] v);
        int r;
        r = -1;
        for (int i = 0; i < N; i++) if (v == (N'(1) << i)) r = i;
        return r;
    endfunction

    task automatic test_reset();
        nRST = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        total++; if (ack !== 4'b0)      begin bad++; $display("FAIL reset_ack: got %b want 0", ack); end
        total++; if (BCEN !== 1'b0)     begin bad++; $display("FAIL reset_bcen: got %b want 0", BCEN); end
        total++; if (BClabel !== '0)    begin bad++; $display("FAIL reset_label: got %0d want 0", BClabel); end
        total++; if (BCdata !== '0)     begin bad++; $display("FAIL reset_data: got %h want 0", BCdata); end
        total++; if (err_label0 !== 0)  begin bad++; $display("FAIL reset_err: got %b want 0", err_label0); end
        nRST = 1'b1;
        m_reset();
        step("idle_after_reset");
    endtask

    task automatic test_single();
        set_unit(2, LABEL_MEM0, 32'hDEADBEEF);
        req = 4'b0100;
        step("single_t1");
        total++;
        if (ack !== 4'b0100 || BCEN !== 1'b1 || BClabel !== LABEL_MEM0 || BCdata !== 32'hDEADBEEF) begin
            bad++; $display("FAIL single_grant: got ack=%b bcen=%b label=%0d data=%h want 0100/1/%0d/deadbeef",
                            ack, BCEN, BClabel, BCdata, LABEL_MEM0);
        end
        step("single_t2");
        total++; if (BCEN !== 1'b0 || BCdata !== '0) begin bad++; $display("FAIL single_idle: got bcen=%b data=%h want 0/0", BCEN, BCdata); end
        req = 4'b0000;
        step("single_drain");
    endtask

    task automatic test_back_to_back();
        set_unit(1, LABEL_ALU0, 32'h1111_0001);
        req = 4'b0010;
        step("b2b_t1");
        total++; if (ack !== 4'b0010) begin bad++; $display("FAIL b2b_t1_ack: got %b want 0010", ack); end
        step("b2b_t2");
        total++; if (BCEN !== 1'b0) begin bad++; $display("FAIL b2b_t2_masked: got bcen=%b want 0", BCEN); end
        step("b2b_t3");
        total++; if (ack !== 4'b0010) begin bad++; $display("FAIL b2b_t3_ack: got %b want 0010", ack); end
        req = 4'b0000;
        step("b2b_drain");
        // ptr should now be 2: with everyone asking, unit 2 goes first.
        set_unit(0, LABEL_MEM1, 32'hA000_0000);
        set_unit(2, LABEL_MULT0, 32'hA000_0002);
        set_unit(3, LABEL_ALU1, 32'hA000_0003);
        req = 4'b1111;
        step("b2b_ptr");
`ifdef CDB_FIXED_PRIO_EN
        total++; if (ack !== 4'b0001) begin bad++; $display("FAIL b2b_ptr: got %b want 0001", ack); end
`else
        total++; if (ack !== 4'b0100) begin bad++; $display("FAIL b2b_ptr: got %b want 0100", ack); end
`endif
        req = 4'b0000;
        step("b2b_drain2");
        step("b2b_drain3");
    endtask

    task automatic test_rr_fairness();
        logic [N-1:0] a_old;
        logic [N-1:0] a_new;
        int prev_w;
        int w;
        int last_g[N];
        a_old  = '0;
        a_new  = '0;
        prev_w = -1;
        for (int i = 0; i < N; i++) last_g[i] = -1;
        for (int c = 0; c < 12; c++) begin
            req = ~a_old;
            step("rr");
            a_old = a_new;
            a_new = m_ack;
            w = onehot_idx(ack);
            if (c > 0) begin
                total++;
                if (w < 0 || w != (prev_w + 1) % N) begin
                    bad++; $display("FAIL rr_order: cycle %0d got ack=%b want unit %0d", c, ack, (prev_w + 1) % N);
                end
            end
            if (w >= 0) begin
                if (last_g[w] >= 0) begin
                    total++;
                    if (c - last_g[w] > N) begin bad++; $display("FAIL rr_wait: unit %0d gap %0d want <= %0d", w, c - last_g[w], N); end
                end
                last_g[w] = c;
            end
            prev_w = w;
        end
        req = 4'b0000;
        step("rr_drain1");
        step("rr_drain2");
    endtask

    task automatic test_equal_labels();
        int n0;
        int n2;
        n0 = 0;
        n2 = 0;
        set_unit(0, 5'd7, 32'h0000_0E00);
        set_unit(2, 5'd7, 32'h0000_0E02);
        req = 4'b0101;
        for (int c = 0; c < 4; c++) begin
            step("eq_label");
            if (ack[0]) n0++;
            if (ack[2]) n2++;
        end
        total++; if (n0 != 2 || n2 != 2) begin bad++; $display("FAIL eq_label_both: got grants u0=%0d u2=%0d want 2/2", n0, n2); end
        req = 4'b0000;
        step("eq_drain1");
        step("eq_drain2");
    endtask

    task automatic test_label0();
        set_unit(3, LABEL_NONE, 32'h0000_0BAD);
        set_unit(0, LABEL_MEM1, 32'hCAFE_0000);
        req = 4'b1001;
        step("lbl0_t1");
        total++; if (err_label0 !== 1'b1) begin bad++; $display("FAIL lbl0_err: got %b want 1", err_label0); end
        total++; if (ack !== 4'b0001)     begin bad++; $display("FAIL lbl0_u0: got %b want 0001", ack); end
        for (int c = 0; c < 4; c++) begin
            step("lbl0_hold");
            total++; if (ack[3] !== 1'b0) begin bad++; $display("FAIL lbl0_never: got ack=%b want bit3=0", ack); end
        end
        req = 4'b0000;
        step("lbl0_drain");
        total++; if (err_label0 !== 1'b1) begin bad++; $display("FAIL lbl0_sticky: got %b want 1", err_label0); end
    endtask

`ifdef CDB_FIXED_PRIO_EN
    task automatic test_fixed_prio();
        logic [N-1:0] prev;
        set_unit(1, LABEL_ALU0, 32'hF1F1_0001);
        set_unit(3, LABEL_MULT1, 32'hF1F1_0003);
        req  = 4'b1010;
        step("fix_t1");
        total++; if (ack !== 4'b0010) begin bad++; $display("FAIL fix_first: got %b want 0010", ack); end
        prev = ack;
        for (int c = 0; c < 6; c++) begin
            step("fix_hold");
            if (ack[3]) begin
                total++; if (prev !== 4'b0010) begin bad++; $display("FAIL fix_u3_only_masked: prev ack=%b want 0010", prev); end
            end
            prev = ack;
        end
        req = 4'b0000;
        step("fix_drain1");
        step("fix_drain2");
    endtask
`endif

    task automatic test_reset_mid();
        set_unit(0, LABEL_MEM0, 32'h5555_0000);
        req = 4'b0001;
        step("rst_pre");
        total++; if (BCEN !== 1'b1) begin bad++; $display("FAIL rst_pre_bcen: got %b want 1", BCEN); end
        nRST = 1'b0;
        #1;
        total++; if (ack !== 4'b0)     begin bad++; $display("FAIL rst_mid_ack: got %b want 0", ack); end
        total++; if (BCEN !== 1'b0)    begin bad++; $display("FAIL rst_mid_bcen: got %b want 0", BCEN); end
        total++; if (BClabel !== '0 || BCdata !== '0) begin bad++; $display("FAIL rst_mid_bus: got %0d/%h want 0/0", BClabel, BCdata); end
        total++; if (err_label0 !== 1'b0) begin bad++; $display("FAIL rst_mid_err: got %b want 0", err_label0); end
        m_reset();
        set_unit(1, LABEL_ALU0, 32'h5555_0001);
        set_unit(2, LABEL_MULT0, 32'h5555_0002);
        set_unit(3, LABEL_ALU1, 32'h5555_0003);
        req = 4'b1111;
        @(posedge clk);
        @(negedge clk);
        nRST = 1'b1;
        step("rst_after");
        total++; if (ack !== 4'b0001) begin bad++; $display("FAIL rst_ptr0: got %b want 0001", ack); end
        req = 4'b0000;
        step("rst_drain");
    endtask

    initial begin
        nRST     = 1'b0;
        req      = '0;
        label_in = '0;
        data_in  = '0;
        m_reset();
        test_reset();
        test_single();
        test_back_to_back();
`ifndef CDB_FIXED_PRIO_EN
        test_rr_fairness();
`endif
        test_equal_labels();
        test_label0();
`ifdef CDB_FIXED_PRIO_EN
        test_fixed_prio();
`endif
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
